// File: rtl/parity_rx_pkg.sv
// Shared types and helpers for the odd-parity serial receiver.
// The state encoding and parity function are shared by the receiver and its checkers.
package parity_rx_pkg;

    localparam int DATA_W_DEF       = 3;
    localparam int CLKS_PER_BIT_DEF = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } rx_state_e;

    // Zero padding leaves the XNOR unchanged, so any word up to 32 bits can be passed.
    function automatic logic odd_parity(input logic [31:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an idle-high asynchronous line; both stages reset to 1.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic ff1_r;
    logic ff2_r;

    // Metastability filter: two back-to-back capture stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_r <= 1'b1;
            ff2_r <= 1'b1;
        end else begin
            ff1_r <= d;
            ff2_r <= ff1_r;
        end
    end

    assign q = ff2_r;

endmodule

// File: rtl/parity3_rx_check.sv
// Framed serial receiver: start, DATA_W bits LSB first, odd parity, stop.
// Reports the recovered word with parity and framing error flags.
module parity3_rx_check
    import parity_rx_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic              rx_s;
    rx_state_e         state_r,      state_nxt_s;
    logic [CNT_W-1:0]  clk_cnt_r,    clk_cnt_nxt_s;
    logic [IDX_W-1:0]  bit_idx_r,    bit_idx_nxt_s;
    logic [DATA_W-1:0] shift_r,      shift_nxt_s;
    logic              p_rx_r,       p_rx_nxt_s;
    logic [DATA_W-1:0] data_out_r,   data_out_nxt_s;
    logic              parity_err_r, parity_err_nxt_s;
    logic              frame_err_r,  frame_err_nxt_s;
    logic              data_valid_r, data_valid_nxt_s;
    logic              busy_r;
    logic              bit_done_s;
    logic              half_done_s;

    sync2 u_sync2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx_in),
        .q     (rx_s)
    );

    // Next-state, bit sampling and result computation.
    always_comb begin
        state_nxt_s      = state_r;
        clk_cnt_nxt_s    = clk_cnt_r;
        bit_idx_nxt_s    = bit_idx_r;
        shift_nxt_s      = shift_r;
        p_rx_nxt_s       = p_rx_r;
        data_out_nxt_s   = data_out_r;
        parity_err_nxt_s = parity_err_r;
        frame_err_nxt_s  = frame_err_r;
        data_valid_nxt_s = 1'b0;
        bit_done_s       = (clk_cnt_r == CNT_W'(CLKS_PER_BIT - 1));
        half_done_s      = (clk_cnt_r == CNT_W'(HALF - 1));

        case (state_r)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt_s   = START;
                    clk_cnt_nxt_s = CNT_W'(0);
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (half_done_s) begin
                    clk_cnt_nxt_s = CNT_W'(0);
                    bit_idx_nxt_s = IDX_W'(0);
                    if (rx_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = DATA;
                    end
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_done_s) begin
                    shift_nxt_s[bit_idx_r] = rx_s;
                    clk_cnt_nxt_s          = CNT_W'(0);
                    if (bit_idx_r == IDX_W'(DATA_W - 1)) begin
                        state_nxt_s = PARITY;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + IDX_W'(1);
                    end
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + CNT_W'(1);
                end
            end
            PARITY: begin
                if (bit_done_s) begin
                    p_rx_nxt_s    = rx_s;
                    clk_cnt_nxt_s = CNT_W'(0);
                    state_nxt_s   = STOP;
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_done_s) begin
                    data_out_nxt_s   = shift_r;
                    parity_err_nxt_s = (p_rx_r != odd_parity(32'(shift_r)));
                    frame_err_nxt_s  = ~rx_s;
                    data_valid_nxt_s = 1'b1;
                    clk_cnt_nxt_s    = CNT_W'(0);
                    if (rx_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = WAIT_HIGH;
                    end
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                // After a broken stop bit a low line is never a new start.
                if (rx_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT_HIGH;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                clk_cnt_nxt_s = CNT_W'(0);
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            clk_cnt_r    <= CNT_W'(0);
            bit_idx_r    <= IDX_W'(0);
            shift_r      <= DATA_W'(0);
            p_rx_r       <= 1'b0;
            data_out_r   <= DATA_W'(0);
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            data_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            clk_cnt_r    <= clk_cnt_nxt_s;
            bit_idx_r    <= bit_idx_nxt_s;
            shift_r      <= shift_nxt_s;
            p_rx_r       <= p_rx_nxt_s;
            data_out_r   <= data_out_nxt_s;
            parity_err_r <= parity_err_nxt_s;
            frame_err_r  <= frame_err_nxt_s;
            data_valid_r <= data_valid_nxt_s;
            busy_r       <= (state_nxt_s != IDLE);
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign parity_err = parity_err_r;
    assign frame_err  = frame_err_r;
    assign busy       = busy_r;

endmodule
